wb_sram_burst_slave: RTL and testbench
======================================

Name: wb_sram_burst_slave

Overview:
- Wishbone B4 slave memory with registered-feedback burst support. Consumes one slave port of the wb interconnect, connecting directly to its sN master-side signals.
- Provides single-beat and incrementing/wrapping burst access to an internal word-addressed SRAM.
- Returns ERR for accesses outside its window.

Parameters:
- WB_ADDR_WIDTH, 32: byte address width.
- WB_DATA_WIDTH, 32: data width, multiple of 8. Byte lanes NB = WB_DATA_WIDTH/8; LB = $clog2(NB).
- MEM_ADDR_BITS, 10: log2 of memory depth in words (default 1024 words).
- BASE_ADDR, 'h0: byte base address of the window; must be NB-aligned.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- ADR  in  WB_ADDR_WIDTH  byte address.
- CTI  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
- BTE  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- DAT_W  in  WB_DATA_WIDTH  write data.
- SEL  in  NB  byte enables.
- CYC  in  1  cycle valid.
- STB  in  1  strobe.
- WE  in  1  1 = write.
- DAT_R  out  WB_DATA_WIDTH  read data, valid only while ACK=1.
- ACK  out  1  registered acknowledge.
- ERR  out  1  registered error.

Behaviour:
- Reset (async assert): ACK=0, ERR=0, DAT_R=0, state=IDLE, ptr=0. Memory contents are not reset.
- Decode: off = ADR - BASE_ADDR (WB_ADDR_WIDTH-bit unsigned). in_range = off < (2**MEM_ADDR_BITS)*NB. Word index = off[LB+:MEM_ADDR_BITS].
- States: IDLE, SINGLE, BURST, ERRST. ACK and ERR are registered; never both 1; ACK/ERR never high while CYC=0 was sampled the previous cycle.
- IDLE: when CYC&STB is sampled:
  - !in_range -> ERRST; ERR=1 for exactly one cycle, then IDLE. No memory write.
  - in_range, CTI=010 -> BURST; ptr=word index; ACK=1 next cycle.
  - in_range, any other CTI (000, 111, reserved) -> SINGLE; ptr=word index; ACK=1 next cycle.
- SINGLE: ACK high one cycle. Return to IDLE with ACK=0. Latency 1 cycle; max single-beat rate 1 per 2 cycles.
- BURST:
  - ACK(t+1) = CYC(t) & STB(t) & !(ACK(t) & CTI(t)==111).
  - Each cycle with ACK=1 completes the beat at ptr; ptr advances at the end of that cycle.
  - STB low pauses: ptr holds, ACK drops the next cycle, and ACK resumes one cycle after STB returns.
  - A beat acked with CTI=111 ends the burst: ACK=0 and state=IDLE next cycle.
  - CYC low at any time: ACK=0 and IDLE next cycle; ptr is discarded.
  - Range check is on the first beat only.
- Pointer advance by BTE:
  - 00: ptr+1 modulo 2**MEM_ADDR_BITS (linear wrap at memory end).
  - 01/10/11: low 2/3/4 bits of ptr increment modulo 4/8/16; upper bits held.
  - ADR of subsequent beats is ignored; the slave predicts.
- Writes: on the clock edge ending a cycle with ACK=1 and WE=1, mem[ptr] byte lane i is updated from DAT_W when SEL[i]=1. SEL=0 lanes are untouched. SEL=0 overall still acks but writes nothing.
- Reads: while ACK=1, DAT_R = mem[ptr] including all writes committed on earlier edges; read-after-write in the next beat returns the new data. DAT_R when ACK=0 is don't-care; the implementation holds its last value.
- WE mixed within a burst is honoured per beat.
- Reset asserted mid-burst: ACK/ERR drop immediately (async), state=IDLE; a write in that cycle is not committed.

Test Plan:
- Single write/read: write ADR=BASE+0x10, DAT_W=0xDEADBEEF, SEL=1111, CTI=000 -> ACK one cycle after STB. Read same address -> ACK+1 cycle, DAT_R=0xDEADBEEF. ACK never high two consecutive cycles.
- Byte enables: write 0x11223344 SEL=1111, then 0xAABBCCDD SEL=0101 -> readback 0x11BB33DD.
- Wrap4 burst: read burst start word 6, BTE=01, 4 beats, last beat CTI=111 -> words 6,7,4,5 returned on 4 consecutive ACK cycles. ACK=0 the cycle after the CTI=111 beat.
- Linear burst at memory end with STB gap: write burst starting word 1022 (BTE=00) for 3 beats, STB low for 2 cycles between beats 1 and 2 -> words 1022,1023,0 written; ACK low during the gap and one cycle after it.
- Out of range: ADR=BASE+4096 (default depth) -> ERR=1 for one cycle, ACK=0, memory unchanged. CYC dropped mid-burst -> ACK=0 next cycle. rst pulse mid-burst -> ACK=0 in the same cycle, state=IDLE.

Source files
------------

// File: rtl/wb_sram_burst_slave_if.sv
// Wishbone B4 bus bundle for one slave port of the interconnect.
// The master modport is the interconnect / bench side; the slave modport is
// the memory side.
interface wb_sram_burst_slave_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
);
    localparam int NB = WB_DATA_WIDTH / 8;

    logic [WB_ADDR_WIDTH-1:0] ADR;
    logic [2:0]               CTI;
    logic [1:0]               BTE;
    logic [WB_DATA_WIDTH-1:0] DAT_W;
    logic [NB-1:0]            SEL;
    logic                     CYC;
    logic                     STB;
    logic                     WE;
    logic [WB_DATA_WIDTH-1:0] DAT_R;
    logic                     ACK;
    logic                     ERR;

    modport master (
        output ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
        output DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_sram_burst_slave.sv
// Wishbone B4 SRAM slave with registered-feedback bursts (linear / wrap4/8/16).
// Memory is split into one byte-wide bank per lane so byte enables map to
// independent write ports.

// One byte lane of the SRAM. The read port bypasses a write landing on the
// same edge so the registered read data never returns stale bytes.
module wb_sram_burst_slave_lane #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:(1<<AW)-1];

    // byte write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // read port with same-edge write forwarding
    always_comb begin
        rdata = mem[raddr];
        if (we && (raddr == waddr))
            rdata = wdata;
    end
endmodule

module wb_sram_burst_slave #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_sram_burst_slave_if.slave  wb
);
    localparam int NB = WB_DATA_WIDTH / 8;
    localparam int LB = (NB > 1) ? $clog2(NB) : 0;
    localparam logic [WB_ADDR_WIDTH:0] WIN_BYTES =
        (WB_ADDR_WIDTH+1)'(1) << (MEM_ADDR_BITS + LB);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SINGLE = 2'd1;
    localparam logic [1:0] S_BURST  = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    logic [1:0]                state, state_nx;
    logic                      ack, ack_nx;
    logic                      err, err_nx;
    logic [MEM_ADDR_BITS-1:0]  ptr, ptr_nx;
    logic [WB_DATA_WIDTH-1:0]  dat_r;

    logic [WB_ADDR_WIDTH-1:0]  off;
    logic                      in_range;
    logic [MEM_ADDR_BITS-1:0]  idx;
    logic                      req;

    logic [NB-1:0][7:0]        wr_bytes;
    logic [NB-1:0][7:0]        rd_word;
    logic [NB-1:0]             lane_we;

    // Next burst address: bits inside the wrap mask count, bits above hold.
    // Linear bursts use a full mask and so wrap at the end of memory.
    function automatic logic [MEM_ADDR_BITS-1:0] adv_ptr(
        input logic [MEM_ADDR_BITS-1:0] p,
        input logic [1:0]               bte
    );
        logic [MEM_ADDR_BITS-1:0] m;
        logic [MEM_ADDR_BITS-1:0] inc;
        inc = p + MEM_ADDR_BITS'(1);
        case (bte)
            2'b01:   m = MEM_ADDR_BITS'(3);
            2'b10:   m = MEM_ADDR_BITS'(7);
            2'b11:   m = MEM_ADDR_BITS'(15);
            default: m = '1;
        endcase
        return (p & ~m) | (inc & m);
    endfunction

    // window decode, only consulted on the first beat
    always_comb begin
        off      = wb.ADR - BASE_ADDR;
        in_range = ({1'b0, off} < WIN_BYTES);
        idx      = off[LB +: MEM_ADDR_BITS];
        req      = wb.CYC & wb.STB;
    end

    // next-state, next-ACK/ERR and pointer prediction
    always_comb begin
        state_nx = state;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        ptr_nx   = ptr;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        state_nx = S_ERR;
                        err_nx   = 1'b1;
                    end else begin
                        ptr_nx   = idx;
                        ack_nx   = 1'b1;
                        state_nx = (wb.CTI == CTI_INC) ? S_BURST : S_SINGLE;
                    end
                end
            end
            S_SINGLE: state_nx = S_IDLE;
            S_BURST: begin
                if (!wb.CYC || (ack && wb.CTI == CTI_EOB)) begin
                    state_nx = S_IDLE;
                end else begin
                    ack_nx = wb.STB;
                    if (ack)
                        ptr_nx = adv_ptr(ptr, wb.BTE);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // a beat completes on every ACK cycle; write lanes gated by SEL
    always_comb begin
        wr_bytes = wb.DAT_W;
        lane_we  = {NB{ack & wb.WE}} & wb.SEL;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            wb_sram_burst_slave_lane #(.AW(MEM_ADDR_BITS)) u_lane (
                .clk   (clk),
                .we    (lane_we[gi]),
                .waddr (ptr),
                .wdata (wr_bytes[gi]),
                .raddr (ptr_nx),
                .rdata (rd_word[gi])
            );
        end
    endgenerate

    // control registers; async reset also suppresses any in-flight write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ack   <= ack_nx;
            err   <= err_nx;
            ptr   <= ptr_nx;
        end
    end

    // read data is loaded for the upcoming ACK cycle and held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dat_r <= '0;
        else if (ack_nx)
            dat_r <= rd_word;
    end

    assign wb.ACK   = ack;
    assign wb.ERR   = err;
    assign wb.DAT_R = dat_r;
endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Directed bench for wb_sram_burst_slave: singles, byte enables, wrap4 and
// linear bursts with a strobe gap, error window, CYC abort and reset abort.
module tb_wb_sram_burst_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_sram_burst_slave_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

    wb_sram_burst_slave #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .MEM_ADDR_BITS (10),
        .BASE_ADDR     (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic w,
                         input logic [2:0] cti, input logic [1:0] bte,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        bus.CYC = c; bus.STB = s; bus.WE = w; bus.CTI = cti; bus.BTE = bte;
        bus.ADR = adr; bus.DAT_W = dat; bus.SEL = sel;
    endtask

    task automatic idle_bus();
        drive(0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h0, 4'h0);
    endtask

    // classic write: ACK one cycle after the strobe is sampled, for one cycle
    task automatic wr_single(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk); drive(1, 1, 1, 3'b000, 2'b00, adr, dat, sel);
        chk("wr_ack_pre", {31'b0, bus.ACK}, 32'd0);
        @(negedge clk);
        chk("wr_ack", {31'b0, bus.ACK}, 32'd1);
        @(negedge clk);
        chk("wr_ack_once", {31'b0, bus.ACK}, 32'd0);
        idle_bus();
    endtask

    task automatic rd_single(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        @(negedge clk); drive(1, 1, 0, 3'b000, 2'b00, adr, 32'h0, 4'hF);
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, bus.ACK}, 32'd1);
        chk({tag, "_err"}, {31'b0, bus.ERR}, 32'd0);
        chk(tag, bus.DAT_R, exp);
        @(negedge clk);
        chk({tag, "_ack_once"}, {31'b0, bus.ACK}, 32'd0);
        idle_bus();
    endtask

    initial begin
        idle_bus();
        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ack", {31'b0, bus.ACK}, 32'd0);
        chk("rst_err", {31'b0, bus.ERR}, 32'd0);
        chk("rst_dat", bus.DAT_R, 32'd0);
        rst = 1'b0;

        // single write / read
        wr_single(32'h10, 32'hDEADBEEF, 4'hF);
        rd_single("single_rd", 32'h10, 32'hDEADBEEF);

        // byte enables: lanes 0 and 2 only
        wr_single(32'h20, 32'h11223344, 4'hF);
        wr_single(32'h20, 32'hAABBCCDD, 4'b0101);
        rd_single("sel_rd", 32'h20, 32'h11BB33DD);
        wr_single(32'h20, 32'hFFFFFFFF, 4'b0000);
        rd_single("sel0_rd", 32'h20, 32'h11BB33DD);

        // wrap4 read burst from word 6: expect 6,7,4,5
        for (int i = 4; i < 8; i++) wr_single(i * 4, 32'hA000_0000 + i, 4'hF);
        @(negedge clk); drive(1, 1, 0, 3'b010, 2'b01, 32'd24, 32'h0, 4'hF);
        @(negedge clk);
        chk("w4_ack0", {31'b0, bus.ACK}, 32'd1); chk("w4_d0", bus.DAT_R, 32'hA000_0006);
        @(negedge clk);
        chk("w4_ack1", {31'b0, bus.ACK}, 32'd1); chk("w4_d1", bus.DAT_R, 32'hA000_0007);
        @(negedge clk);
        chk("w4_ack2", {31'b0, bus.ACK}, 32'd1); chk("w4_d2", bus.DAT_R, 32'hA000_0004);
        @(negedge clk); bus.CTI = 3'b111;
        chk("w4_ack3", {31'b0, bus.ACK}, 32'd1); chk("w4_d3", bus.DAT_R, 32'hA000_0005);
        @(negedge clk);
        chk("w4_end", {31'b0, bus.ACK}, 32'd0);
        idle_bus();

        // linear write burst across memory end, STB gap after beat 1
        @(negedge clk); drive(1, 1, 1, 3'b010, 2'b00, 32'd4088, 32'hC000_0000, 4'hF);
        @(negedge clk);
        chk("lin_ack0", {31'b0, bus.ACK}, 32'd1);
        @(negedge clk); bus.DAT_W = 32'hC000_0001; bus.STB = 1'b0;
        chk("lin_ack1", {31'b0, bus.ACK}, 32'd1);
        @(negedge clk);
        chk("lin_gap0", {31'b0, bus.ACK}, 32'd0);
        @(negedge clk); bus.DAT_W = 32'hC000_0002; bus.STB = 1'b1; bus.CTI = 3'b111;
        chk("lin_gap1", {31'b0, bus.ACK}, 32'd0);
        @(negedge clk);
        chk("lin_ack2", {31'b0, bus.ACK}, 32'd1);
        @(negedge clk); idle_bus();
        chk("lin_end", {31'b0, bus.ACK}, 32'd0);
        rd_single("lin_w1022", 32'd4088, 32'hC000_0000);
        rd_single("lin_w1023", 32'd4092, 32'hC000_0001);
        rd_single("lin_w0",    32'd0,    32'hC000_0002);

        // out of range write: ERR one cycle, no ACK, word 0 untouched
        @(negedge clk); drive(1, 1, 1, 3'b000, 2'b00, 32'd4096, 32'h0BAD_0BAD, 4'hF);
        @(negedge clk);
        chk("oor_err", {31'b0, bus.ERR}, 32'd1);
        chk("oor_ack", {31'b0, bus.ACK}, 32'd0);
        idle_bus();
        @(negedge clk);
        chk("oor_err_once", {31'b0, bus.ERR}, 32'd0);
        rd_single("oor_mem", 32'd0, 32'hC000_0002);

        // CYC dropped mid-burst
        @(negedge clk); drive(1, 1, 0, 3'b010, 2'b00, 32'd16, 32'h0, 4'hF);
        @(negedge clk);
        chk("cyc_d0", bus.DAT_R, 32'hA000_0004);
        @(negedge clk); idle_bus();
        chk("cyc_ack1", {31'b0, bus.ACK}, 32'd1);
        chk("cyc_d1", bus.DAT_R, 32'hA000_0005);
        @(negedge clk);
        chk("cyc_drop", {31'b0, bus.ACK}, 32'd0);

        // reset mid-burst: ACK falls at once, second beat not committed
        wr_single(32'd404, 32'h0BAD_0101, 4'hF);
        @(negedge clk); drive(1, 1, 1, 3'b010, 2'b00, 32'd400, 32'h5555_0001, 4'hF);
        @(negedge clk);
        chk("rb_ack0", {31'b0, bus.ACK}, 32'd1);
        @(negedge clk); bus.DAT_W = 32'h5555_0002;
        chk("rb_ack1", {31'b0, bus.ACK}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rb_async", {31'b0, bus.ACK}, 32'd0);
        @(negedge clk); idle_bus(); rst = 1'b0;
        rd_single("rb_w100", 32'd400, 32'h5555_0001);
        rd_single("rb_w101", 32'd404, 32'h0BAD_0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
